neuron_mac_sequencer: RTL

//  Sequences one neuron dot-product through the shared 8x8 pipelined multiplier (8x8_Mult_Piped).
//  Per term, reads a weight/input pair from operand memory and streams it into the multiplier.

---
 rtl/nn_pkg.sv | 45 ++++
 rtl/mac_tag_pipe.sv | 27 ++
 rtl/neuron_mac_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared constants, FSM encodings and the saturating accumulate step for the neuron MAC sequencer.
// Combinational helpers only; no latency and no flow control live here.
package nn_pkg;

  localparam int MUL_LAT   = 8;
  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int ACC_MAX_W = 32;
  localparam int SUM_W     = ACC_MAX_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  typedef struct packed {
    logic                    sat;
    logic signed [SUM_W-1:0] sum;
  } sat_res_t;

  // acc must already be sign-extended from acc_w bits; the result is clamped to the acc_w range.
  function automatic sat_res_t sat_add(input logic signed [ACC_MAX_W-1:0] acc,
                                       input logic signed [PROD_W-1:0]    prod,
                                       input int                          acc_w);
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_max;
    logic signed [SUM_W-1:0] w_min;
    sat_res_t                res;
    w_sum   = SUM_W'(acc) + SUM_W'(prod);
    w_max   = SUM_W'(1) <<< (acc_w - 1);
    w_max   = w_max - SUM_W'(1);
    w_min   = -w_max - SUM_W'(1);
    res.sat = 1'b0;
    res.sum = w_sum;
    if (w_sum > w_max) begin
      res.sat = 1'b1;
      res.sum = w_max;
    end else if (w_sum < w_min) begin
      res.sat = 1'b1;
      res.sum = w_min;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Valid-only shift register that tracks which multiplier outputs belong to issued reads.
// DEPTH cycles from i_vld to o_tail_vld; never stalls.
module mac_tag_pipe #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  output logic o_tail_vld,
  output logic o_empty
);

  logic [DEPTH-1:0] r_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= {r_vld[DEPTH-2:0], i_vld};
    end
  end

  assign o_tail_vld = r_vld[DEPTH-1];
  // Ignores the tail: the pipe is empty once the current edge retires it.
  assign o_empty    = ~|r_vld[DEPTH-2:0];

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Issues len operand reads into the external multiplier and saturating-accumulates the products.
// Result valid len+MUL_LAT+2 cycles after start; issue never stalls, res_ready only gates leaving OUT.
module neuron_mac_sequencer #(
  parameter int MUL_LAT = nn_pkg::MUL_LAT,
  parameter int ADDR_W  = 6,
  parameter int ACC_W   = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W:0]           len,
  output logic                      busy,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [nn_pkg::OP_W-1:0]   rd_weight,
  input  logic [nn_pkg::OP_W-1:0]   rd_input,
  output logic [nn_pkg::OP_W-1:0]   mul_a,
  output logic [nn_pkg::OP_W-1:0]   mul_b,
  input  logic [nn_pkg::PROD_W-1:0] mul_y,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [ACC_W-1:0]          res_data,
  output logic                      sat_flag
);
  import nn_pkg::*;

  localparam logic [ADDR_W:0] CNT_ONE = 1;

  logic [1:0]              r_state;
  logic [ADDR_W:0]         r_len;
  logic [ADDR_W:0]         r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_sat;

  logic                    w_tail_vld;
  logic                    w_empty;
  logic                    w_last;
  logic                    w_accept;
  logic [ADDR_W:0]         w_cnt_inc;
  sat_res_t                w_sat;
  logic [SUM_W-ACC_W:0]    w_unused_hi;

  assign w_cnt_inc   = r_cnt + CNT_ONE;
  assign w_last      = (w_cnt_inc == r_len);
  assign w_accept    = (r_state == ST_IDLE) && start;
  assign w_sat       = sat_add(ACC_MAX_W'(r_acc), mul_y, ACC_W);
  assign w_unused_hi = w_sat.sum[SUM_W-1:ACC_W-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_len   <= len;
            r_cnt   <= '0;
            r_state <= (len == '0) ? ST_OUT : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt <= w_cnt_inc;
          if (w_last) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Only tagged products are summed; the multiplier pipe itself is never reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (w_tail_vld) begin
      r_acc <= w_sat.sum[ACC_W-1:0];
      if (w_sat.sat) begin
        r_sat <= 1'b1;
      end
    end
  end

  mac_tag_pipe #(
    .DEPTH(MUL_LAT + 1)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (reset),
    .i_vld     (rd_en),
    .o_tail_vld(w_tail_vld),
    .o_empty   (w_empty)
  );

  assign busy      = (r_state != ST_IDLE);
  assign rd_en     = (r_state == ST_ISSUE);
  assign rd_addr   = rd_en ? r_cnt[ADDR_W-1:0] : '0;
  assign mul_a     = busy ? rd_weight : '0;
  assign mul_b     = busy ? rd_input : '0;
  assign res_valid = (r_state == ST_OUT);
  assign res_data  = r_acc;
  assign sat_flag  = r_sat;

endmodule
